// File: rtl/bip_fetch_unit_if.sv
// bip_fetch_unit_if
// Bus bundle between the BIP I fetch unit, its synchronous program memory
// and the instruction decoder/datapath.
//   master : fetch unit side (drives memory address/read, presents instructions)
//   slave  : memory + decoder side (returns ProgData, accepts via InstrReady)
// Signals:
//   ProgAddr/ProgRd/ProgData - program memory read port (data one cycle after read)
//   Opcode/Operand/Pc        - instruction presented to the decoder
//   InstrValid/InstrReady    - valid/ready handshake for the instruction
interface bip_fetch_unit_if #(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11
);
  logic [PC_WIDTH-1:0]      ProgAddr;
  logic                     ProgRd;
  logic [15:0]              ProgData;
  logic [OPCODE_WIDTH-1:0]  Opcode;
  logic [OPERAND_WIDTH-1:0] Operand;
  logic                     InstrValid;
  logic                     InstrReady;
  logic [PC_WIDTH-1:0]      Pc;

  modport master (
    output ProgAddr, ProgRd, Opcode, Operand, InstrValid, Pc,
    input  ProgData, InstrReady
  );

  modport slave (
    input  ProgAddr, ProgRd, Opcode, Operand, InstrValid, Pc,
    output ProgData, InstrReady
  );
endinterface

// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit
// Instruction fetch unit for the BIP I processor. Owns the program counter,
// reads one 16-bit word at a time from synchronous program memory, splits it
// into opcode/operand and issues it to the decoder over a valid/ready
// handshake. Fetching stops after HLT (opcode 0) has been issued.
// Ports:
//   clk, reset - system clock (rising edge), synchronous active-high reset
//   Start      - pulse, begins fetching from the current PC (IDLE only)
//   bus        - bip_fetch_unit_if.master (program memory + instruction handshake)
//   Halted     - fetch stopped; left only by reset
//   IllegalOp  - illegal opcode (8..31) trapped; exists only when the
//                FETCH_ILLEGAL_HALT_EN macro is defined
// Optional feature macro: FETCH_ILLEGAL_HALT_EN
//
// state | meaning
// IDLE  | waiting for Start
// REQ   | ProgRd=1, ProgAddr=PC for one cycle
// CAPT  | memory data arrives, captured at end of cycle
// ISSUE | InstrValid=1, held until handshake
// HALT  | stopped after HLT (or illegal opcode)
module bip_fetch_unit #(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  bip_fetch_unit_if.master  bus,
  output logic              Halted
`ifdef FETCH_ILLEGAL_HALT_EN
  ,
  output logic              IllegalOp
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, CAPT, ISSUE, HALT} state_t;

  state_t                   state, state_next;
  logic [PC_WIDTH-1:0]      pc;
  logic                     start_armed;
  logic [OPCODE_WIDTH-1:0]  capt_opcode;
  logic [OPERAND_WIDTH-1:0] capt_operand;
  logic                     illegal_word;
  logic                     handshake;

  assign capt_opcode  = bus.ProgData[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
  assign capt_operand = bus.ProgData[OPERAND_WIDTH-1:0];
  assign handshake    = (state == ISSUE) && bus.InstrReady;

`ifdef FETCH_ILLEGAL_HALT_EN
  assign illegal_word = (capt_opcode > OPCODE_WIDTH'(7));
`else
  assign illegal_word = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start && start_armed) state_next = REQ;
      REQ:     state_next = CAPT;
      CAPT:    state_next = illegal_word ? HALT : ISSUE;
      ISSUE:   if (bus.InstrReady) state_next = (bus.Opcode == '0) ? HALT : REQ;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // start_armed blocks a Start sampled on the first edge after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      start_armed <= 1'b0;
      bus.Opcode  <= '0;
      bus.Operand <= '0;
      bus.Pc      <= '0;
    end else begin
      start_armed <= 1'b1;
      if (state == CAPT) begin
        bus.Opcode  <= capt_opcode;
        bus.Operand <= capt_operand;
        bus.Pc      <= pc;
      end
      // HLT keeps the PC pointing at itself; wrap is natural modulo 2^PC_WIDTH
      if (handshake && (bus.Opcode != '0)) pc <= pc + PC_WIDTH'(1);
    end
  end

`ifdef FETCH_ILLEGAL_HALT_EN
  always_ff @(posedge clk) begin
    if (reset)                              IllegalOp <= 1'b0;
    else if ((state == CAPT) && illegal_word) IllegalOp <= 1'b1;
  end
`endif

  assign bus.ProgRd     = (state == REQ);
  assign bus.ProgAddr   = (state == REQ) ? pc : '0;
  assign bus.InstrValid = (state == ISSUE);
  assign Halted         = (state == HALT);

endmodule

// File: tb/tb_bip_fetch_unit.sv
module tb_bip_fetch_unit;

  typedef struct packed {
    logic [4:0]  op;
    logic [10:0] opr;
    logic [10:0] pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, Start, Halted;
  logic start_w, halted_w;
`ifdef FETCH_ILLEGAL_HALT_EN
  logic IllegalOp, illegal_w;
`endif

  bip_fetch_unit_if #(.PC_WIDTH(11), .OPCODE_WIDTH(5), .OPERAND_WIDTH(11)) bus ();
  bip_fetch_unit_if #(.PC_WIDTH(3),  .OPCODE_WIDTH(5), .OPERAND_WIDTH(11)) bus_w ();

  bip_fetch_unit #(.PC_WIDTH(11), .OPCODE_WIDTH(5), .OPERAND_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .Start(Start), .bus(bus), .Halted(Halted)
`ifdef FETCH_ILLEGAL_HALT_EN
    , .IllegalOp(IllegalOp)
`endif
  );

  bip_fetch_unit #(.PC_WIDTH(3), .OPCODE_WIDTH(5), .OPERAND_WIDTH(11)) dut_w (
    .clk(clk), .reset(reset), .Start(start_w), .bus(bus_w), .Halted(halted_w)
`ifdef FETCH_ILLEGAL_HALT_EN
    , .IllegalOp(illegal_w)
`endif
  );

  logic [15:0] rom   [0:2047];
  logic [15:0] rom_w [0:7];

  always @(posedge clk) if (bus.ProgRd)   bus.ProgData   <= rom[bus.ProgAddr];
  always @(posedge clk) if (bus_w.ProgRd) bus_w.ProgData <= rom_w[bus_w.ProgAddr];

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb [$];
  logic [2:0] sb_w [$];
  int   lat;
  logic seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; Start = 1'b0; start_w = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Wait (bounded) for InstrValid, then compare against the scoreboard head.
  task automatic expect_issue(input string tag, output int cycles);
    exp_t e;
    cycles = 0;
    while (bus.InstrValid !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    check({tag, " valid"}, {31'd0, bus.InstrValid}, 32'd1);
    check({tag, " sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    check({tag, " opcode"},  {27'd0, bus.Opcode},  {27'd0, e.op});
    check({tag, " operand"}, {21'd0, bus.Operand}, {21'd0, e.opr});
    check({tag, " pc"},      {21'd0, bus.Pc},      {21'd0, e.pc});
  endtask

  initial begin
    bus.InstrReady   = 1'b1;
    bus_w.InstrReady = 1'b1;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 8; i++)    rom_w[i] = 16'h2000;

    // Reset state, with Start held across reset release
    reset = 1'b1; Start = 1'b1; start_w = 1'b0;
    tick(); tick();
    check("rst ProgAddr",   {21'd0, bus.ProgAddr}, 0);
    check("rst ProgRd",     {31'd0, bus.ProgRd}, 0);
    check("rst Opcode",     {27'd0, bus.Opcode}, 0);
    check("rst Operand",    {21'd0, bus.Operand}, 0);
    check("rst InstrValid", {31'd0, bus.InstrValid}, 0);
    check("rst Pc",         {21'd0, bus.Pc}, 0);
    check("rst Halted",     {31'd0, Halted}, 0);
`ifdef FETCH_ILLEGAL_HALT_EN
    check("rst IllegalOp",  {31'd0, IllegalOp}, 0);
`endif
    reset = 1'b0;
    tick();
    Start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen |= bus.ProgRd | bus.InstrValid;
      tick();
    end
    check("start_at_release ignored", {31'd0, seen}, 0);

    // Basic program: LDI 5, ADDI 3, HLT
    do_reset();
    rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0000;
    sb.push_back('{op: 5'd3, opr: 11'd5, pc: 11'd0});
    sb.push_back('{op: 5'd5, opr: 11'd3, pc: 11'd1});
    sb.push_back('{op: 5'd0, opr: 11'd0, pc: 11'd2});
    bus.InstrReady = 1'b1;
    pulse_start();
    check("t1 req ProgRd",   {31'd0, bus.ProgRd}, 1);
    check("t1 req ProgAddr", {21'd0, bus.ProgAddr}, 0);
    expect_issue("t1 i0", lat);
    check("t1 first latency", lat, 2);
    tick();
    check("t1 next ProgRd",   {31'd0, bus.ProgRd}, 1);
    check("t1 next ProgAddr", {21'd0, bus.ProgAddr}, 1);
    expect_issue("t1 i1", lat);
    check("t1 issue interval", lat, 2);
    tick();
    expect_issue("t1 i2", lat);
    tick();
    check("t1 Halted",     {31'd0, Halted}, 1);
    check("t1 InstrValid", {31'd0, bus.InstrValid}, 0);
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen |= bus.ProgRd | bus.InstrValid | ~Halted;
      tick();
    end
    check("t1 halt quiet", {31'd0, seen}, 0);

    // Backpressure, with a Start pulse while stalled in ISSUE
    do_reset();
    rom[0] = 16'h3807; rom[1] = 16'h1001;
    sb.push_back('{op: 5'd7, opr: 11'd7, pc: 11'd0});
    sb.push_back('{op: 5'd2, opr: 11'd1, pc: 11'd1});
    bus.InstrReady = 1'b0;
    pulse_start();
    expect_issue("bp i0", lat);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) Start = 1'b1;
      tick();
      Start = 1'b0;
      check("bp stall valid",   {31'd0, bus.InstrValid}, 1);
      check("bp stall opcode",  {27'd0, bus.Opcode}, 7);
      check("bp stall operand", {21'd0, bus.Operand}, 7);
      check("bp stall pc",      {21'd0, bus.Pc}, 0);
      check("bp stall ProgRd",  {31'd0, bus.ProgRd}, 0);
    end
    bus.InstrReady = 1'b1;
    tick();
    check("bp req ProgRd",   {31'd0, bus.ProgRd}, 1);
    check("bp req ProgAddr", {21'd0, bus.ProgAddr}, 1);
    tick();
    check("bp single pulse", {31'd0, bus.ProgRd}, 0);
    expect_issue("bp i1", lat);
    tick();

    // Reset during CAPT discards the in-flight word
    do_reset();
    rom[0] = 16'h2801;
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    check("capt_rst Opcode",     {27'd0, bus.Opcode}, 0);
    check("capt_rst ProgRd",     {31'd0, bus.ProgRd}, 0);
    check("capt_rst InstrValid", {31'd0, bus.InstrValid}, 0);
    reset = 1'b0;
    tick();
    check("capt_rst stale opcode",  {27'd0, bus.Opcode}, 0);
    check("capt_rst stale operand", {21'd0, bus.Operand}, 0);
    check("capt_rst no valid",      {31'd0, bus.InstrValid}, 0);
    sb.push_back('{op: 5'd5, opr: 11'd1, pc: 11'd0});
    pulse_start();
    check("capt_rst refetch addr", {21'd0, bus.ProgAddr}, 0);
    check("capt_rst refetch rd",   {31'd0, bus.ProgRd}, 1);
    expect_issue("capt_rst i0", lat);
    tick();

    // Opcode 8
    do_reset();
    rom[0] = 16'h4000; rom[1] = 16'h0000;
`ifdef FETCH_ILLEGAL_HALT_EN
    pulse_start();
    tick();
    tick();
    check("ill Halted",    {31'd0, Halted}, 1);
    check("ill IllegalOp", {31'd0, IllegalOp}, 1);
    check("ill Opcode",    {27'd0, bus.Opcode}, 8);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen |= bus.InstrValid | bus.ProgRd | ~IllegalOp;
      tick();
    end
    check("ill quiet", {31'd0, seen}, 0);
`else
    sb.push_back('{op: 5'd8, opr: 11'd0, pc: 11'd0});
    sb.push_back('{op: 5'd0, opr: 11'd0, pc: 11'd1});
    pulse_start();
    expect_issue("op8 i0", lat);
    tick();
    check("op8 next addr", {21'd0, bus.ProgAddr}, 1);
    check("op8 next rd",   {31'd0, bus.ProgRd}, 1);
    expect_issue("op8 i1", lat);
    tick();
    check("op8 Halted", {31'd0, Halted}, 1);
`endif

    // PC wrap on the 3-bit instance
    for (int k = 0; k < 10; k++) sb_w.push_back(3'(k % 8));
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic [2:0] ep;
      lat = 0;
      while (bus_w.InstrValid !== 1'b1 && lat < 50) begin
        tick();
        lat++;
      end
      check("wrap valid", {31'd0, bus_w.InstrValid}, 1);
      ep = (sb_w.size() > 0) ? sb_w.pop_front() : 'x;
      check($sformatf("wrap pc%0d", k), {29'd0, bus_w.Pc}, {29'd0, ep});
      check("wrap no halt", {31'd0, halted_w}, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_fetch_unit.md
# bip_fetch_unit

Instruction fetch unit for the BIP I processor: owns the program counter, reads 16-bit instruction words from the synchronous program memory, and presents each split opcode/operand pair to the instruction decoder and datapath through a valid/ready handshake. It is the producer end of the opcode interface that the instruction decoder consumes. It stops fetching after issuing HLT (opcode 0).

## Interface
Parameters:
- PC_WIDTH, 11, program counter and program memory address width
- OPCODE_WIDTH, 5, opcode field width, instruction bits [15:11]
- OPERAND_WIDTH, 11, operand field width, instruction bits [10:0]

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  single-cycle pulse that starts fetching from the current PC
- ProgAddr  out  PC_WIDTH  program memory read address
- ProgRd  out  1  program memory read enable
- ProgData  in  16  program memory read data, valid one cycle after ProgRd
- Opcode  out  OPCODE_WIDTH  opcode to the instruction decoder
- Operand  out  OPERAND_WIDTH  operand to the datapath
- InstrValid  out  1  Opcode/Operand hold a valid instruction
- InstrReady  in  1  datapath accepts the instruction this cycle
- Pc  out  PC_WIDTH  address of the instruction currently in Opcode/Operand
- Halted  out  1  fetch stopped after HLT (or illegal opcode, see Configuration)
- IllegalOp  out  1  illegal opcode trapped; present only with FETCH_ILLEGAL_HALT_EN

## Operation
- On reset, all outputs are 0 and the state is IDLE. This covers ProgAddr, ProgRd, Opcode, Operand, InstrValid, Pc, Halted and IllegalOp.
- The state machine has five states: IDLE, REQ, CAPT, ISSUE and HALT.
- IDLE: wait for Start=1, then go to REQ. Start is ignored in every other state.
- REQ: drive ProgRd=1 and ProgAddr=PC for exactly one cycle, then go to CAPT.
- CAPT: ProgRd=0. At the end of the cycle, register ProgData[15:11]→Opcode, ProgData[10:0]→Operand and PC→Pc. Go to ISSUE.
- ISSUE: InstrValid=1. Opcode, Operand and Pc are held stable until InstrValid && InstrReady.
- On the ISSUE handshake, if Opcode==0 (HLT), go to HALT and leave PC unchanged.
- On the ISSUE handshake for any other opcode, set PC ← PC+1 modulo 2^PC_WIDTH and go to REQ.
- HALT: Halted=1, InstrValid=0, ProgRd=0. The block leaves HALT only on reset.
- HLT is itself issued to the decoder, so the datapath sees it before the block stops.
- The internal PC is not reset by Start. Start after reset always begins at address 0.
- Legal opcodes are 0..7 (HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI). Opcodes 8..31 are passed through unchanged unless FETCH_ILLEGAL_HALT_EN is defined.
- The block never speculates. At most one outstanding memory read exists at any time.

## Timing
- Start is sampled at edge N. ProgRd=1 during cycle N+1, Opcode is valid with InstrValid=1 from cycle N+3.
- Minimum issue interval is 3 cycles per instruction (REQ, CAPT, ISSUE) when InstrReady is held at 1.
- Each cycle of InstrReady=0 in ISSUE adds one cycle. Outputs do not change while stalled.
- PC wrap: the instruction at address 2^PC_WIDTH-1 is followed by address 0. No flag is raised.
- Reset is sampled at a clock edge and takes priority over everything, including a simultaneous Start or handshake. An in-flight read is discarded, and ProgData is ignored on the following cycle.
- Start asserted on the same edge that reset is deasserted is ignored. A new Start is required.

## Configuration
- Macro: FETCH_ILLEGAL_HALT_EN.
- Defined:
  - In CAPT, if ProgData[15:11] > 7, Opcode/Operand/Pc are still captured, but the next state is HALT instead of ISSUE.
  - InstrValid never rises for the illegal word.
  - Halted=1 and IllegalOp=1 from the cycle after CAPT until reset.
- Not defined:
  - The IllegalOp port does not exist.
  - All opcodes are issued normally.
  - Halt occurs only on HLT.

## Test plan
- Reset, then Start with ROM[0..2] = {LDI 5, ADDI 3, HLT} = 16'h1805, 16'h2803, 16'h0000, and InstrReady=1. Required: three issues with Opcode 3, 5, 0, Operand 5, 3, 0, Pc 0, 1, 2. Halted=1 from the cycle after the third handshake. ProgRd never rises again.
- Backpressure: hold InstrReady=0 for 4 cycles in ISSUE. Required: InstrValid=1 and Opcode/Operand/Pc stable for all 4 cycles. A single ProgRd pulse follows the handshake.
- Wrap, with PC_WIDTH=3 and ROM[0..7] = ADD (16'h2000). Required: the Pc sequence is 7 followed by 0. Fetching continues with no Halted.
- Reset asserted during CAPT. Required: the next cycle has all outputs 0, the state is IDLE, and stale ProgData is not captured. Start then fetches from address 0.
- Start pulses while in ISSUE and HALT have no effect. Start asserted at the same edge as reset release has no effect.
- With FETCH_ILLEGAL_HALT_EN and ROM[0] = 16'h4000 (opcode 8): InstrValid stays 0, Halted=1 and IllegalOp=1. Without the macro, the word issues with Opcode=8 and the next fetch reads address 1.
